// File: rtl/aes_round_key_gen.sv
// aes_round_key_gen
// Expands a 128- or 256-bit AES cipher key into the full round-key schedule
// (11 or 15 entries of 128 bits) and holds it for zero-latency indexed reads
// by the round engines. One entry is produced per clock; SubWord is borrowed
// from a shared external combinational S-box via sboxw/new_sboxw.

module aes_round_key_gen (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  localparam int unsigned NUM_ENTRIES = 15;
  localparam logic [3:0]  NR_AES128   = 4'd10;
  localparam logic [3:0]  NR_AES256   = 4'd14;
  localparam logic [7:0]  RCON_INIT   = 8'h01;

  // Control and schedule state
  state_t         state_q, state_d;
  logic [3:0]     roundCtr_q, roundCtr_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [255:0]   keyReg_q, keyReg_d;
  logic           keylenReg_q, keylenReg_d;
  logic           ready_q, ready_d;
  logic [127:0]   entry_q [0:NUM_ENTRIES-1];

  // Datapath nets
  logic           entryWe;
  logic [127:0]   entryWdata;
  logic           rconStep;
  logic [3:0]     lastCtr;
  logic [3:0]     prevIdx;
  logic [3:0]     prev2Idx;
  logic [127:0]   prevKey;
  logic [127:0]   prev2Key;
  logic [127:0]   baseKey;
  logic [31:0]    tWord;
  logic [31:0]    k0, k1, k2, k3;
  logic           useRcon;

  // Multiply-by-x in GF(2^8) with the AES reduction polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Cyclic left rotate of a word by one byte
  function automatic logic [31:0] rotByte(input logic [31:0] w);
    rotByte = {w[23:0], w[31:24]};
  endfunction

  assign lastCtr = keylenReg_q ? NR_AES256 : NR_AES128;

  // Locate the previous one and two entries, clamped so a zero counter never
  // produces an out-of-range index (those cycles do not use them anyway)
  always_comb begin
    prevIdx  = 4'd0;
    prev2Idx = 4'd0;
    if (roundCtr_q >= 4'd1) begin
      prevIdx = roundCtr_q - 4'd1;
    end
    if (roundCtr_q >= 4'd2) begin
      prev2Idx = roundCtr_q - 4'd2;
    end
  end

  assign prevKey  = entry_q[prevIdx];
  assign prev2Key = entry_q[prev2Idx];

  // AES-256 builds each entry from the one two steps back, AES-128 from the previous
  assign baseKey = keylenReg_q ? prev2Key : prevKey;

  // Compute the entry for the current counter and drive the shared S-box
  always_comb begin
    sboxw      = 32'h0;
    entryWdata = 128'h0;
    rconStep   = 1'b0;
    useRcon    = 1'b0;
    tWord      = 32'h0;
    k0         = 32'h0;
    k1         = 32'h0;
    k2         = 32'h0;
    k3         = 32'h0;
    if (state_q == GEN) begin
      if (roundCtr_q == 4'd0) begin
        entryWdata = keyReg_q[255:128];
      end else if (keylenReg_q && (roundCtr_q == 4'd1)) begin
        entryWdata = keyReg_q[127:0];
      end else begin
        sboxw   = prevKey[31:0];
        useRcon = !keylenReg_q || !roundCtr_q[0];
        if (useRcon) begin
          tWord    = rotByte(new_sboxw) ^ {rcon_q, 24'h0};
          rconStep = 1'b1;
        end else begin
          tWord = new_sboxw;
        end
        k0 = baseKey[127:96] ^ tWord;
        k1 = baseKey[95:64]  ^ k0;
        k2 = baseKey[63:32]  ^ k1;
        k3 = baseKey[31:0]   ^ k2;
        entryWdata = {k0, k1, k2, k3};
      end
    end
  end

  // Next-state logic: accept init only in IDLE, step once per entry in GEN
  always_comb begin
    state_d     = state_q;
    roundCtr_d  = roundCtr_q;
    rcon_d      = rcon_q;
    keyReg_d    = keyReg_q;
    keylenReg_d = keylenReg_q;
    ready_d     = ready_q;
    entryWe     = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) begin
          keyReg_d    = key;
          keylenReg_d = keylen;
          roundCtr_d  = 4'd0;
          rcon_d      = RCON_INIT;
          ready_d     = 1'b0;
          state_d     = GEN;
        end
      end
      GEN: begin
        entryWe = 1'b1;
        if (rconStep) begin
          rcon_d = xtime(rcon_q);
        end
        if (roundCtr_q == lastCtr) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          roundCtr_d = roundCtr_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Control registers, cleared to an idle schedule on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      roundCtr_q  <= 4'd0;
      rcon_q      <= RCON_INIT;
      keyReg_q    <= 256'h0;
      keylenReg_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      roundCtr_q  <= roundCtr_d;
      rcon_q      <= rcon_d;
      keyReg_q    <= keyReg_d;
      keylenReg_q <= keylenReg_d;
      ready_q     <= ready_d;
    end
  end

  // Round-key storage, wiped on reset so a partial schedule is never visible
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_q[i] <= 128'h0;
      end
    end else if (entryWe) begin
      entry_q[roundCtr_q] <= entryWdata;
    end
  end

  // Zero-latency read port; the one index past the table reads as zero
  always_comb begin
    round_key = 128'h0;
    if (round <= 4'd14) begin
      round_key = entry_q[round];
    end
  end

  assign ready = ready_q;

endmodule
